// File: rtl/add_share_pkg.sv
// Shared types and defaults for the time-shared adder controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package add_share_pkg;

    // Controller phases: waiting for work, adder settling, result held.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NREQ       = 4;
    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADD_CYCLES = 2;

    // Width needed to index n items; never less than one bit.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell, the building block of the ripple chain.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports: a, b, ci -> s (sum), co (carry-out).
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/ripple_adder.sv
// Structural WIDTH-bit ripple-carry adder with carry-in and carry-out.
// Latency: combinational; the carry chain is long, so its consumer allows a multicycle window.
// Backpressure: n/a.
//
// Ports: a, b (WIDTH), cin -> sum (WIDTH+1, carry-out in MSB).
module ripple_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fulladder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_c[i]),
            .s  (sum[i]),
            .co (w_c[i+1])
        );
    end

    assign sum[WIDTH] = w_c[WIDTH];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant picker: first requester after ptr (wrapping) wins.
// Latency: combinational; the pointer register lives in the parent.
// Backpressure: en low forces an all-zero grant.
//
// Ports: req (NREQ), ptr (last granted index), en -> grant (one-hot or zero).
module rr_arbiter
    import add_share_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int TAG_W = tag_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [TAG_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  grant
);

    logic w_found;
    int   w_idx;

    // Walk ptr+1, ptr+2, ... wrapping once; the first asserted request wins.
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (en && !w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_share_ctrl.sv
// Time-shares one ripple-carry adder among NREQ requesters with round-robin arbitration.
// Latency: result valid ADD_CYCLES edges after the accept edge; one op per ADD_CYCLES+1 cycles.
// Backpressure: result held while res_ready is low; no new grant until it is consumed.
//
// Ports: clk, rst_n (async, active-low);
//        req_valid/req_ready (per requester), req_a/req_b (NREQ*WIDTH slices), req_cin;
//        res_valid/res_ready, res_sum (WIDTH+1, carry-out in MSB), res_tag (requester index).
module add_share_ctrl
    import add_share_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADD_CYCLES = DEF_ADD_CYCLES,
    parameter int TAG_W      = tag_width(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [WIDTH:0]          res_sum,
    output logic [TAG_W-1:0]        res_tag
);

    localparam int               CNT_W    = tag_width(ADD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_CYCLES - 1);
    localparam logic [TAG_W-1:0] PTR_RST  = TAG_W'(NREQ - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_cin;
    logic [TAG_W-1:0]   r_tag;
    logic [CNT_W-1:0]   r_cnt;
    logic [TAG_W-1:0]   r_ptr;

    logic               w_arb_en;
    logic [NREQ-1:0]    w_grant;
    logic               w_accept;
    logic [TAG_W-1:0]   w_gnt_idx;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic               w_sel_cin;
    logic [WIDTH:0]     w_sum;

    // Grants are offered when idle, or when the held result leaves this cycle.
    // Gating with rst_n keeps req_ready low for the whole reset assertion.
    assign w_arb_en = rst_n & ((r_state == IDLE) | ((r_state == DONE) & res_ready));

    rr_arbiter #(
        .NREQ  (NREQ),
        .TAG_W (TAG_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (r_ptr),
        .en    (w_arb_en),
        .grant (w_grant)
    );

    assign req_ready = w_grant;
    assign w_accept  = |(req_valid & w_grant);

    // One-hot grant to index plus operand select; this feeds the latches only.
    always_comb begin
        w_gnt_idx = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_idx = TAG_W'(i);
                w_sel_a   = req_a[i*WIDTH +: WIDTH];
                w_sel_b   = req_b[i*WIDTH +: WIDTH];
                w_sel_cin = req_cin[i];
            end
        end
    end

    // Adder sees only latched operands, so r_a/r_b/r_cin -> res_sum is the
    // sole multicycle path (ADD_CYCLES cycles).
    ripple_adder #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (r_a),
        .b   (r_b),
        .cin (r_cin),
        .sum (w_sum)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ADD;
                end
            end
            ADD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_state_nxt = w_accept ? ADD : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cin     <= 1'b0;
            r_tag     <= '0;
            r_cnt     <= '0;
            r_ptr     <= PTR_RST;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_tag   <= '0;
        end else begin
            // Consume; a same-edge accept below starts the next operation.
            if ((r_state == DONE) && res_ready) begin
                res_valid <= 1'b0;
            end

            if (r_state == ADD) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    res_sum   <= w_sum;
                    res_tag   <= r_tag;
                    res_valid <= 1'b1;
                end
            end

            if (w_accept) begin
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_cin <= w_sel_cin;
                r_tag <= w_gnt_idx;
                r_cnt <= CNT_LOAD;
                r_ptr <= w_gnt_idx;
            end
        end
    end

endmodule
